mux_rr_pipe: RTL and testbench

- Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes on every port.
- Generalises the combinational 2:1 64-bit mux: N requesters share one output register, selected by round-robin or fixed-priority arbitration.
- Sits between producer stages in the pipelined CPU, for example for shared write-back or memory-request paths.
- Gives one-cycle latency and full throughput of one transfer per cycle.

---
 rtl/mux_rr_pipe_pkg.sv | 6 +
 rtl/mux_rr_pipe_rr_arbiter.sv | 29 ++
 rtl/mux_rr_pipe.sv | 56 +++++
 tb/tb_mux_rr_pipe.sv | 110 +++++++++++
 4 files changed

// File: rtl/mux_rr_pipe_pkg.sv
// mux_rr_pipe_pkg: shared helper for channel-index width
package mux_rr_pipe_pkg;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_rr_pipe_rr_arbiter.sv
// mux_rr_pipe_rr_arbiter: combinational round-robin/fixed-priority grant (req, last_grant -> grant one-hot, grant_idx, any)
module mux_rr_pipe_rr_arbiter
  import mux_rr_pipe_pkg::*;
#(
  parameter int N = 4,
  parameter int RR = 1,
  localparam int SELW = sel_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last_grant,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any
);
  logic [2*N-1:0] dbl;
  int start;
  always_comb begin
    start = (RR != 0 && int'(last_grant) < N - 1) ? int'(last_grant) + 1 : 0;
    dbl = '0;
    for (int i = 0; i < N; i++) begin
      dbl[i] = req[i] && (i >= start);
      dbl[N+i] = req[i];
    end
    grant_idx = '0;
    for (int i = 2 * N - 1; i >= 0; i--) grant_idx = dbl[i] ? SELW'(i % N) : grant_idx;
    any = |req;
    grant = any ? (N'(1) << grant_idx) : '0;
  end
endmodule

// File: rtl/mux_rr_pipe.sv
// mux_rr_pipe: N-input registered valid/ready mux (in_data/in_valid/in_ready -> out_data/out_sel/out_valid/out_ready), async active-low reset
module mux_rr_pipe
  import mux_rr_pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N = 4,
  parameter int RR = 1,
  localparam int SELW = sel_w(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready
);
  logic [N-1:0] grant;
  logic [SELW-1:0] grant_idx, last_q, last_d, sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic any, can_load, load, valid_q, valid_d;
  mux_rr_pipe_rr_arbiter #(.N(N), .RR(RR)) u_arb (
    .req(in_valid),
    .last_grant(last_q),
    .grant(grant),
    .grant_idx(grant_idx),
    .any(any)
  );
  always_comb begin
    can_load = !valid_q || out_ready;
    load = can_load && any;
    in_ready = can_load ? grant : '0;
    data_d = load ? in_data[int'(grant_idx)*WIDTH +: WIDTH] : data_q;
    sel_d = load ? grant_idx : sel_q;
    valid_d = load ? 1'b1 : (out_ready ? 1'b0 : valid_q);
    last_d = (load && RR != 0) ? grant_idx : last_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      sel_q <= '0;
      valid_q <= 1'b0;
      last_q <= SELW'(N - 1);
    end else begin
      data_q <= data_d;
      sel_q <= sel_d;
      valid_q <= valid_d;
      last_q <= last_d;
    end
  end
  assign out_data = data_q;
  assign out_sel = sel_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_mux_rr_pipe.sv
// tb_mux_rr_pipe: table-driven check of round-robin and fixed-priority mux_rr_pipe
module tb_mux_rr_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [255:0] in_data;
  logic [3:0] in_valid = '0;
  logic out_ready = 1'b1;
  logic [3:0] rdy_rr, rdy_fp;
  logic [63:0] data_rr, data_fp;
  logic [1:0] sel_rr, sel_fp;
  logic ov_rr, ov_fp;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [3:0] v;
    logic r;
    logic [3:0] rdy;
    logic ov;
    logic [1:0] sel;
    logic [63:0] data;
  } vec_t;
  vec_t vec [14];
  localparam logic [63:0] D0 = 64'hDEAD_BEEF_0000_0000;
  localparam logic [63:0] D1 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] D2 = 64'hDEAD_BEEF_0000_0002;
  localparam logic [63:0] D3 = 64'hDEAD_BEEF_0000_0003;
  always #5 clk = ~clk;
  mux_rr_pipe #(.WIDTH(64), .N(4), .RR(1)) u_rr (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_rr),
    .out_data(data_rr), .out_sel(sel_rr), .out_valid(ov_rr), .out_ready(out_ready)
  );
  mux_rr_pipe #(.WIDTH(64), .N(4), .RR(0)) u_fp (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_fp),
    .out_data(data_fp), .out_sel(sel_fp), .out_valid(ov_fp), .out_ready(out_ready)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic [3:0] v, input logic r, input logic fp,
                      input logic [3:0] er, input logic eov, input logic [1:0] es, input logic [63:0] ed);
    @(negedge clk);
    in_valid = v;
    out_ready = r;
    #1;
    chk("in_ready", fp ? rdy_fp : rdy_rr, er);
    @(posedge clk);
    #1;
    chk("out_valid", fp ? ov_fp : ov_rr, eov);
    chk("out_sel", fp ? sel_fp : sel_rr, es);
    chk("out_data", fp ? data_fp : data_rr, ed);
  endtask
  task automatic set_data(input logic [63:0] c0, input logic [63:0] c1, input logic [63:0] c2, input logic [63:0] c3);
    in_data = {c3, c2, c1, c0};
  endtask
  initial begin
    vec[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
    vec[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
    vec[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
    vec[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
    vec[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
    vec[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
    vec[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, D1};
    vec[7]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
    vec[8]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
    vec[9]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
    vec[10] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
    vec[11] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
    vec[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, D0};
    vec[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, D0};
    set_data(D0, D1, D2, D3);
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {ov_rr, ov_fp}, 2'b00);
    chk("reset out_data", data_rr | data_fp, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    step(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 64'h0);
    step(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0);
    for (int i = 0; i < 14; i++)
      step(vec[i].v, vec[i].r, 1'b0, vec[i].rdy, vec[i].ov, vec[i].sel, vec[i].data);
    set_data(64'h0A, 64'h11, 64'h22, 64'h33);
    step(4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 64'h11);
    repeat (3) step(4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 64'h11);
    step(4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 64'h33);
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 64'h33);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async reset out_valid", ov_rr, 1'b0);
    chk("async reset out_sel", sel_rr, 2'd0);
    chk("async reset out_data", data_rr, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    set_data(D0, D1, D2, D3);
    step(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, D0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) step(4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, D1);
    step(4'b1000, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, D3);
    step(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd3, D3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
